// File: rtl/reflet_irq_arbiter.sv
// Interrupt request arbiter: per-line synchronizers, edge/level capture into
// pending latches, and a fixed-priority presenter with an ack handshake.
module reflet_irq_arbiter #(
    parameter int                  CHANNELS    = 4,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] EDGE_MASK   = {CHANNELS{1'b1}}
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [CHANNELS-1:0]         irq_in,
    input  logic [CHANNELS-1:0]         mask,
    input  logic                        ack,
    input  logic [CHANNELS-1:0]         overrun_clr,
    output logic                        irq_valid,
    output logic [$clog2(CHANNELS)-1:0] irq_id,
    output logic [CHANNELS-1:0]         pending,
    output logic [CHANNELS-1:0]         overrun
);
    localparam int         ID_W      = $clog2(CHANNELS);
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_BUBBLE  = 2'd2
    } state_t;

    logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
    logic [CHANNELS-1:0] hist_r;
    logic [CHANNELS-1:0] pending_r;
    logic [CHANNELS-1:0] overrun_r;
    logic [2:0]          warm_r;
    state_t              state_r;
    state_t              state_nx_s;
    logic                valid_r;
    logic [ID_W-1:0]     id_r;

    logic [CHANNELS-1:0] sync_last_s;
    logic [CHANNELS-1:0] edge_s;
    logic [CHANNELS-1:0] set_s;
    logic [CHANNELS-1:0] clr_s;
    logic [CHANNELS-1:0] elig_s;
    logic                win_found_s;
    logic [ID_W-1:0]     win_id_s;
    logic                grant_s;

    assign sync_last_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain, one-cycle edge history and post-reset warm-up counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= {CHANNELS{1'b0}};
            end
            hist_r <= {CHANNELS{1'b0}};
            warm_r <= 3'd0;
        end else begin
            sync_r[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
            hist_r <= sync_last_s;
            if (warm_r != WARM_DONE) begin
                warm_r <= warm_r + 3'd1;
            end else begin
                warm_r <= warm_r;
            end
        end
    end

    // Capture events, clear on ack, and pick the lowest-index eligible channel
    always_comb begin
        edge_s   = {CHANNELS{1'b0}};
        set_s    = {CHANNELS{1'b0}};
        clr_s    = {CHANNELS{1'b0}};
        win_id_s = {ID_W{1'b0}};
        // Edges stay suppressed until the history holds a genuine post-reset
        // sample, so a line held high through reset is not mistaken for an edge.
        if (warm_r == WARM_DONE) begin
            edge_s = sync_last_s & ~hist_r & EDGE_MASK;
        end else begin
            edge_s = {CHANNELS{1'b0}};
        end
        set_s       = edge_s | (sync_last_s & ~EDGE_MASK);
        elig_s      = pending_r & mask;
        win_found_s = |elig_s;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            win_id_s = elig_s[i] ? ID_W'(i) : win_id_s;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            clr_s[i] = (state_r == ST_PRESENT) && ack && (id_r == ID_W'(i));
        end
    end

    // Presenter next-state logic
    always_comb begin
        state_nx_s = state_r;
        grant_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && win_found_s) begin
                    state_nx_s = ST_PRESENT;
                    grant_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (ack) begin
                    state_nx_s = ST_BUBBLE;
                end else if (!enable) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_PRESENT;
                end
            end
            ST_BUBBLE: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Presenter state, registered valid and latched winner id
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            id_r    <= {ID_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            valid_r <= (state_nx_s == ST_PRESENT);
            if (grant_s) begin
                id_r <= win_id_s;
            end else begin
                id_r <= id_r;
            end
        end
    end

    // Pending and sticky overrun latches; a new set beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {CHANNELS{1'b0}};
            overrun_r <= {CHANNELS{1'b0}};
        end else begin
            pending_r <= (pending_r & ~clr_s) | set_s;
            overrun_r <= (overrun_r & ~overrun_clr) | (edge_s & pending_r & ~clr_s);
        end
    end

    assign irq_valid = valid_r;
    assign irq_id    = id_r;
    assign pending   = pending_r;
    assign overrun   = overrun_r;
endmodule

// File: tb/tb_reflet_irq_arbiter.sv
// Self-checking bench for reflet_irq_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-level behavioural model.
module tb_reflet_irq_arbiter;
    localparam logic [3:0] EM = 4'b1110;  // channel 0 is level-captured

    logic       clk = 1'b0;
    logic       reset, enable, ack;
    logic [3:0] irq_in, mask, overrun_clr;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [3:0] pending, overrun;

    int vectors = 0;
    int errors  = 0;

    // model state
    logic [3:0] m_pend, m_ov;
    logic       m_valid, m_bub;
    logic [1:0] m_id;
    logic [3:0] hq[$];

    always #5 clk = ~clk;

    reflet_irq_arbiter #(.CHANNELS(4), .SYNC_STAGES(2), .EDGE_MASK(EM)) dut (
        .clk(clk), .reset(reset), .enable(enable), .irq_in(irq_in), .mask(mask),
        .ack(ack), .overrun_clr(overrun_clr), .irq_valid(irq_valid), .irq_id(irq_id),
        .pending(pending), .overrun(overrun)
    );

    // Advance the model by one clock using the inputs currently applied, then clock the DUT.
    task automatic tick();
        logic [3:0] seen, prev, edg, setv, clrv, elig;
        logic [1:0] win;
        if (reset) begin
            m_pend = 4'd0; m_ov = 4'd0; m_valid = 1'b0; m_bub = 1'b0; m_id = 2'd0;
            hq.delete();
        end else begin
            seen = (hq.size() >= 2) ? hq[1] : 4'd0;
            prev = (hq.size() >= 3) ? hq[2] : 4'd0;
            edg  = (hq.size() >= 3) ? (seen & ~prev & EM) : 4'd0;
            setv = edg | (seen & ~EM);
            clrv = (m_valid && ack) ? (4'b0001 << m_id) : 4'd0;
            elig = m_pend & mask;
            win  = 2'd0;
            for (int i = 3; i >= 0; i--) if (elig[i]) win = 2'(i);
            m_ov   = (m_ov & ~overrun_clr) | (edg & m_pend & ~clrv);
            m_pend = (m_pend & ~clrv) | setv;
            if (m_valid) begin
                if (ack) begin m_valid = 1'b0; m_bub = 1'b1; end
                else if (!enable) m_valid = 1'b0;
            end else if (m_bub) begin
                m_bub = 1'b0;
            end else if (enable && (elig != 4'd0)) begin
                m_valid = 1'b1; m_id = win;
            end
            hq.push_front(irq_in);
            if (hq.size() > 3) void'(hq.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; ack = 1'b0; irq_in = 4'd0;
        mask = 4'hF; overrun_clr = 4'd0;
        tick();
        reset = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        irq_in = 4'hF; reset = 1'b1; enable = 1'b0; ack = 1'b0; mask = 4'hF; overrun_clr = 4'd0;
        repeat (2) tick();
        vectors++;
        if ({irq_valid, irq_id, pending, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b id=%0d pend=%b ov=%b, want all zero",
                     irq_valid, irq_id, pending, overrun);
        end
        reset = 1'b0;
        repeat (8) begin
            tick();
            vectors++;
            if ({irq_valid, irq_id, pending, overrun} !== {m_valid, m_id, m_pend, m_ov}) begin
                errors++;
                $display("FAIL reset_release: got v=%0b id=%0d pend=%b ov=%b, want v=%0b id=%0d pend=%b ov=%b",
                         irq_valid, irq_id, pending, overrun, m_valid, m_id, m_pend, m_ov);
            end
        end
        vectors++;
        if (pending !== 4'b0001 || overrun !== 4'd0) begin
            errors++;
            $display("FAIL held_high_no_edge: got pend=%b ov=%b, want pend=0001 ov=0000", pending, overrun);
        end
    endtask

    task automatic test_pulse_latency();
        do_reset();
        enable = 1'b1;
        irq_in = 4'b0010; tick();
        irq_in = 4'b0000; tick(); tick();
        vectors++;
        if (pending !== 4'b0010 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL pend_latency: got pend=%b v=%0b, want pend=0010 v=0", pending, irq_valid);
        end
        tick();
        vectors++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd1) begin
            errors++;
            $display("FAIL valid_latency: got v=%0b id=%0d, want v=1 id=1", irq_valid, irq_id);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        vectors++;
        if (pending !== 4'd0 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: got pend=%b v=%0b, want pend=0000 v=0", pending, irq_valid);
        end
        tick();
        vectors++;
        if (irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_low: got v=%0b, want v=0", irq_valid);
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        enable = 1'b1;
        irq_in = 4'b0100; tick(); irq_in = 4'd0;
        repeat (3) tick();
        irq_in = 4'b0001; tick(); irq_in = 4'd0;
        repeat (5) begin
            tick();
            vectors++;
            if (irq_valid !== 1'b1 || irq_id !== 2'd2) begin
                errors++;
                $display("FAIL no_preempt: got v=%0b id=%0d, want v=1 id=2", irq_valid, irq_id);
            end
        end
        ack = 1'b1; tick(); ack = 1'b0;
        tick(); tick();
        vectors++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd0 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL next_winner: got v=%0b id=%0d pend=%b, want v=1 id=0 pend=0001",
                     irq_valid, irq_id, pending);
        end
    endtask

    task automatic test_mask();
        do_reset();
        enable = 1'b1; mask = 4'b1101;
        irq_in = 4'b0010; tick(); irq_in = 4'd0;
        repeat (6) tick();
        vectors++;
        if (pending !== 4'b0010 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL masked_hold: got pend=%b v=%0b, want pend=0010 v=0", pending, irq_valid);
        end
        mask = 4'hF; tick();
        vectors++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd1) begin
            errors++;
            $display("FAIL unmask_present: got v=%0b id=%0d, want v=1 id=1", irq_valid, irq_id);
        end
        mask = 4'b0000; repeat (3) tick();
        vectors++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd1) begin
            errors++;
            $display("FAIL mask_while_present: got v=%0b id=%0d, want v=1 id=1", irq_valid, irq_id);
        end
        enable = 1'b0; tick();
        vectors++;
        if (irq_valid !== 1'b0 || pending !== 4'b0010) begin
            errors++;
            $display("FAIL disable_keeps_pending: got v=%0b pend=%b, want v=0 pend=0010", irq_valid, pending);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        irq_in = 4'b1000; tick(); irq_in = 4'd0;
        repeat (3) tick();
        irq_in = 4'b1000; tick(); irq_in = 4'd0;
        repeat (3) tick();
        vectors++;
        if (overrun !== 4'b1000 || pending !== 4'b1000) begin
            errors++;
            $display("FAIL overrun_set: got ov=%b pend=%b, want ov=1000 pend=1000", overrun, pending);
        end
        overrun_clr = 4'b1000; tick(); overrun_clr = 4'd0;
        vectors++;
        if (overrun !== 4'd0 || pending !== 4'b1000) begin
            errors++;
            $display("FAIL overrun_clr: got ov=%b pend=%b, want ov=0000 pend=1000", overrun, pending);
        end
    endtask

    task automatic test_level_repeat();
        do_reset();
        enable = 1'b1; irq_in = 4'b0001;
        repeat (4) tick();
        vectors++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin
            errors++;
            $display("FAIL level_present: got v=%0b id=%0d, want v=1 id=0", irq_valid, irq_id);
        end
        ack = 1'b1; tick(); ack = 1'b0;
        vectors++;
        if (pending !== 4'b0001 || irq_valid !== 1'b0) begin
            errors++;
            $display("FAIL level_reset_wins: got pend=%b v=%0b, want pend=0001 v=0", pending, irq_valid);
        end
        tick(); tick();
        vectors++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd0) begin
            errors++;
            $display("FAIL level_represent: got v=%0b id=%0d, want v=1 id=0", irq_valid, irq_id);
        end
        irq_in = 4'd0;
    endtask

    task automatic test_reset_mid_present();
        do_reset();
        enable = 1'b1;
        irq_in = 4'b1010; tick(); irq_in = 4'd0;
        repeat (3) tick();
        vectors++;
        if (irq_valid !== 1'b1 || irq_id !== 2'd1 || pending !== 4'b1010) begin
            errors++;
            $display("FAIL pre_reset_present: got v=%0b id=%0d pend=%b, want v=1 id=1 pend=1010",
                     irq_valid, irq_id, pending);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        vectors++;
        if ({irq_valid, irq_id, pending, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_present: got v=%0b id=%0d pend=%b ov=%b, want all zero",
                     irq_valid, irq_id, pending, overrun);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            irq_in      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
            enable      = ($urandom_range(0, 7) != 0);
            ack         = ($urandom_range(0, 2) == 0);
            overrun_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            reset       = ($urandom_range(0, 199) == 0);
            tick();
            vectors++;
            if ({irq_valid, irq_id, pending, overrun} !== {m_valid, m_id, m_pend, m_ov}) begin
                errors++;
                $display("FAIL random[%0d]: got v=%0b id=%0d pend=%b ov=%b, want v=%0b id=%0d pend=%b ov=%b",
                         n, irq_valid, irq_id, pending, overrun, m_valid, m_id, m_pend, m_ov);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pulse_latency();
        test_no_preempt();
        test_mask();
        test_overrun();
        test_level_repeat();
        test_reset_mid_present();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
